// File: rtl/eth_dma_cmd_responder_pkg.sv
// Shared types and widths for the Ethernet debug-DMA command responder.
package eth_dma_cmd_responder_pkg;

    localparam int unsigned DMA_CNT_W  = 16;
    localparam int unsigned DMA_ADDR_W = 32;
    localparam int unsigned DMA_DATA_W = 32;
    localparam int unsigned DMA_OUT_W  = 4;

    typedef enum logic {
        DMA_OP_READ  = 1'b0,
        DMA_OP_WRITE = 1'b1
    } dma_resp_op_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_RUN   = 3'd1,
        ST_RD_DRAIN = 3'd2,
        ST_WR_FETCH = 3'd3,
        ST_WR_REQ   = 3'd4,
        ST_FIN      = 3'd5
    } dma_resp_state_t;

endpackage

// File: rtl/eth_dma_rd_tracker.sv
// Read-side bookkeeping: issued/received/outstanding counters and the
// outstanding-request credit check.
module eth_dma_rd_tracker
    import eth_dma_cmd_responder_pkg::*;
#(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clear_i,
    input  logic [DMA_CNT_W-1:0] count_i,
    input  logic                 gnt_i,
    input  logic                 rvalid_i,
    output logic [DMA_CNT_W-1:0] issued_o,
    output logic [DMA_CNT_W-1:0] received_o,
    output logic                 can_issue_o,
    output logic                 issue_done_o,
    output logic                 rd_complete_o
);

    logic [DMA_CNT_W-1:0] issued_q, issued_d;
    logic [DMA_CNT_W-1:0] received_q, received_d;
    logic [DMA_OUT_W-1:0] out_q, out_d;

    always_comb begin
        issued_d   = issued_q;
        received_d = received_q;
        out_d      = out_q;
        if (clear_i) begin
            issued_d   = '0;
            received_d = '0;
            out_d      = '0;
        end else begin
            if (gnt_i)    issued_d   = issued_q + DMA_CNT_W'(1);
            if (rvalid_i) received_d = received_q + DMA_CNT_W'(1);
            // A grant and a response in the same cycle cancel out.
            if (gnt_i && !rvalid_i)      out_d = out_q + DMA_OUT_W'(1);
            else if (!gnt_i && rvalid_i) out_d = out_q - DMA_OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issued_q   <= '0;
            received_q <= '0;
            out_q      <= '0;
        end else begin
            issued_q   <= issued_d;
            received_q <= received_d;
            out_q      <= out_d;
        end
    end

    assign issued_o      = issued_q;
    assign received_o    = received_q;
    assign can_issue_o   = (issued_q < count_i) && (out_q < DMA_OUT_W'(MAX_OUT));
    assign issue_done_o  = (issued_q == count_i);
    assign rd_complete_o = (received_q == count_i);

endmodule

// File: rtl/eth_dma_cmd_responder.sv
// Debug-DMA command target: executes one READ (mem->write buffer) or
// WRITE (read buffer->mem) command at a time and reports idle on dma_done.
module eth_dma_cmd_responder
    import eth_dma_cmd_responder_pkg::*;
#(
    parameter int unsigned BUF_AW  = 10,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    input  logic                  cmd_op,
    input  logic [DMA_ADDR_W-1:0] cmd_addr,
    input  logic [BUF_AW-1:0]     cmd_buf_addr,
    input  logic [DMA_CNT_W-1:0]  cmd_count,
    output logic                  cmd_ack,
    output logic                  dma_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DMA_ADDR_W-1:0] mem_addr,
    output logic [DMA_DATA_W-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DMA_DATA_W-1:0] mem_rdata,
    output logic                  rb_re,
    output logic [BUF_AW-1:0]     rb_addr,
    input  logic [DMA_DATA_W-1:0] rb_rdata,
    output logic                  wb_we,
    output logic [BUF_AW-1:0]     wb_addr,
    output logic [DMA_DATA_W-1:0] wb_wdata
);

    dma_resp_state_t       state_q, state_d;
    logic [DMA_ADDR_W-1:0] addr_q, addr_d;
    logic [BUF_AW-1:0]     buf_q, buf_d;
    logic [DMA_CNT_W-1:0]  count_q, count_d;
    logic [DMA_CNT_W-1:0]  sent_q, sent_d;
    logic [DMA_DATA_W-1:0] hold_q, hold_d;
    logic                  cap_q, cap_d;
    logic                  ack_q, ack_d;
    logic                  done_q, done_d;

    logic                  trk_clear;
    logic                  rd_active, rd_gnt, rd_rvalid;
    logic                  can_issue, issue_done, rd_complete;
    logic [DMA_CNT_W-1:0]  issued, received;

    assign rd_active = (state_q == ST_RD_RUN) || (state_q == ST_RD_DRAIN);
    assign rd_gnt    = mem_gnt && (state_q == ST_RD_RUN) && can_issue;
    assign rd_rvalid = mem_rvalid && rd_active;

    eth_dma_rd_tracker #(
        .MAX_OUT (MAX_OUT)
    ) u_rd_tracker (
        .clk           (clk),
        .rstn          (rstn),
        .clear_i       (trk_clear),
        .count_i       (count_q),
        .gnt_i         (rd_gnt),
        .rvalid_i      (rd_rvalid),
        .issued_o      (issued),
        .received_o    (received),
        .can_issue_o   (can_issue),
        .issue_done_o  (issue_done),
        .rd_complete_o (rd_complete)
    );

    // Next-state logic; dma_done stays low through FIN and the first IDLE cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        buf_d     = buf_q;
        count_d   = count_q;
        sent_d    = sent_q;
        hold_d    = hold_q;
        cap_d     = cap_q;
        done_d    = done_q;
        ack_d     = 1'b0;
        trk_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!done_q) begin
                    done_d = 1'b1;
                end else if (cmd_valid) begin
                    ack_d     = 1'b1;
                    done_d    = 1'b0;
                    addr_d    = cmd_addr;
                    buf_d     = cmd_buf_addr;
                    count_d   = cmd_count;
                    sent_d    = '0;
                    trk_clear = 1'b1;
                    if (cmd_count == '0)                            state_d = ST_FIN;
                    else if (dma_resp_op_t'(cmd_op) == DMA_OP_WRITE) state_d = ST_WR_FETCH;
                    else                                            state_d = ST_RD_RUN;
                end
            end
            ST_RD_RUN: begin
                if (issue_done) state_d = ST_RD_DRAIN;
            end
            ST_RD_DRAIN: begin
                if (rd_complete) state_d = ST_FIN;
            end
            ST_WR_FETCH: begin
                cap_d   = 1'b1;
                state_d = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (cap_q) begin
                    hold_d = rb_rdata;
                    cap_d  = 1'b0;
                end else if (mem_gnt) begin
                    sent_d  = sent_q + DMA_CNT_W'(1);
                    state_d = (sent_q + DMA_CNT_W'(1) == count_q) ? ST_FIN : ST_WR_FETCH;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            buf_q   <= '0;
            count_q <= '0;
            sent_q  <= '0;
            hold_q  <= '0;
            cap_q   <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            count_q <= count_d;
            sent_q  <= sent_d;
            hold_q  <= hold_d;
            cap_q   <= cap_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    // Memory port: derived from registered state only, so a pending request
    // and its address/data cannot change until it is granted.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if ((state_q == ST_RD_RUN) && can_issue) begin
            mem_req  = 1'b1;
            mem_addr = addr_q + DMA_ADDR_W'(issued);
        end else if ((state_q == ST_WR_REQ) && !cap_q) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q + DMA_ADDR_W'(sent_q);
            mem_wdata = hold_q;
        end
    end

    assign rb_re    = (state_q == ST_WR_FETCH);
    assign rb_addr  = rb_re ? (buf_q + BUF_AW'(sent_q)) : '0;
    assign wb_we    = rd_rvalid;
    assign wb_addr  = wb_we ? (buf_q + BUF_AW'(received)) : '0;
    assign wb_wdata = wb_we ? mem_rdata : '0;
    assign cmd_ack  = ack_q;
    assign dma_done = done_q;

endmodule

// File: tb/tb_eth_dma_cmd_responder.sv
// Scoreboard bench for eth_dma_cmd_responder: memory/buffer models, directed
// scenarios and randomized commands checked against a transfer-level model.
module tb_eth_dma_cmd_responder;

    localparam int unsigned BUF_AW  = 10;
    localparam int unsigned BUF_N   = 1 << BUF_AW;
    localparam int unsigned MAX_OUT = 4;
    localparam logic [31:0] RD_KEY  = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_op;
    logic [31:0] cmd_addr;
    logic [BUF_AW-1:0] cmd_buf_addr;
    logic [15:0] cmd_count;
    logic        cmd_ack, dma_done;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        rb_re, wb_we;
    logic [BUF_AW-1:0] rb_addr, wb_addr;
    logic [31:0] rb_rdata, wb_wdata;

    eth_dma_cmd_responder #(.BUF_AW(BUF_AW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_buf_addr(cmd_buf_addr), .cmd_count(cmd_count),
        .cmd_ack(cmd_ack), .dma_done(dma_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rb_re(rb_re), .rb_addr(rb_addr), .rb_rdata(rb_rdata),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_wdata(wb_wdata)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] data; } rsp_t;

    int passed = 0;
    int total  = 0;

    logic [31:0] rb_mem [BUF_N];
    logic [31:0] wb_mem [BUF_N];
    logic [63:0] exp_wb[$];
    logic [63:0] exp_mw[$];
    rsp_t        pipe[$];

    int lat = 2, gnt_pct = 100, hold_gnt = 0;
    bit stray_en = 1'b0;
    int cyc = 0, ncyc = 0, last_due = 0;
    int ack_cnt, rise_cnt, low_cnt, act_cnt, wb_seen = 0;
    int last_ack_cyc = 0, last_rise_cyc = 0;
    int out_cnt = 0, max_out = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory and read-buffer models, driven just after each rising edge.
    initial begin
        bit          prev_re = 1'b0;
        logic [BUF_AW-1:0] prev_addr = '0;
        int          req_wait = 0;
        bit          g;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; rb_rdata = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rstn) begin
                pipe.delete();
                last_due = 0;
                mem_gnt = 1'b0; mem_rvalid = 1'b0; req_wait = 0; prev_re = 1'b0;
            end else begin
                if (stray_en) begin
                    mem_rvalid = 1'b1; mem_rdata = $urandom;
                end else if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                    mem_rvalid = 1'b1; mem_rdata = pipe[0].data;
                    void'(pipe.pop_front());
                end else begin
                    mem_rvalid = 1'b0; mem_rdata = $urandom;
                end
                g = 1'b0;
                if (mem_req) begin
                    if (mem_we && hold_gnt > 0) begin
                        if (req_wait >= hold_gnt) g = 1'b1;
                        else req_wait++;
                    end else begin
                        g = ($urandom_range(99) < gnt_pct);
                    end
                end
                if (g) begin
                    req_wait = 0;
                    if (!mem_we) begin
                        rsp_t r;
                        r.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                        r.data = mem_addr ^ RD_KEY;
                        last_due = r.due;
                        pipe.push_back(r);
                    end
                end
                mem_gnt  = g;
                rb_rdata = prev_re ? rb_mem[prev_addr] : $urandom;
                prev_re   = rb_re;
                prev_addr = rb_addr;
            end
        end
    end

    // Monitor: scoreboard pops, request stability and handshake bookkeeping.
    initial begin
        bit          pend = 1'b0, prev_done = 1'b1;
        logic [31:0] p_addr = '0, p_data = '0;
        logic [63:0] got, exp;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rstn) begin
                out_cnt = 0; pend = 1'b0; prev_done = 1'b1;
                continue;
            end
            if (cmd_ack) begin ack_cnt++; last_ack_cyc = ncyc; end
            if (dma_done && !prev_done) begin rise_cnt++; last_rise_cyc = ncyc; end
            prev_done = dma_done;
            if (!dma_done) low_cnt++;
            if (mem_req || wb_we || rb_re) act_cnt++;
            if (wb_we) begin
                wb_mem[wb_addr] = wb_wdata;
                wb_seen++;
                got = {32'(wb_addr), wb_wdata};
                if (exp_wb.size() == 0) chk(1'b0, "wb_unexpected", got, 64'h0);
                else begin exp = exp_wb.pop_front(); chk(got == exp, "wb_word", got, exp); end
            end
            if (mem_req && mem_we && mem_gnt) begin
                got = {mem_addr, mem_wdata};
                if (exp_mw.size() == 0) chk(1'b0, "mw_unexpected", got, 64'h0);
                else begin exp = exp_mw.pop_front(); chk(got == exp, "mem_write", got, exp); end
            end
            if (pend)
                chk(mem_req && mem_we && mem_addr == p_addr && mem_wdata == p_data,
                    "req_stable", {mem_req, mem_addr}, {1'b1, p_addr});
            pend   = mem_req && mem_we && !mem_gnt;
            p_addr = mem_addr;
            p_data = mem_wdata;
            if (mem_req && !mem_we && mem_gnt) out_cnt++;
            if (mem_rvalid && !stray_en) out_cnt--;
            if (out_cnt > max_out) max_out = out_cnt;
        end
    end

    task automatic push_expect(input bit op, input logic [31:0] addr, input int bufa, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [31:0] a;
            int          b;
            a = addr + 32'(i);
            b = (bufa + i) % BUF_N;
            if (!op) exp_wb.push_back({32'(b), a ^ RD_KEY});
            else     exp_mw.push_back({a, rb_mem[b]});
        end
    endtask

    task automatic issue_cmd(input bit op, input logic [31:0] addr, input int bufa, input int cnt);
        bit got = 1'b0;
        push_expect(op, addr, bufa, cnt);
        cmd_op = op; cmd_addr = addr; cmd_buf_addr = BUF_AW'(bufa); cmd_count = 16'(cnt);
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (cmd_ack) got = 1'b1;
        end
        if (!got) chk(1'b0, "ack_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge clk); #1;
            if (dma_done) ok = 1'b1;
        end
        if (!ok) chk(1'b0, "done_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk(exp_wb.size() == 0 && exp_mw.size() == 0, "sb_drained",
            64'(exp_wb.size() + exp_mw.size()), 0);
    endtask

    task automatic run_cmd(input bit op, input logic [31:0] addr, input int bufa, input int cnt);
        ack_cnt = 0; rise_cnt = 0; low_cnt = 0; act_cnt = 0;
        issue_cmd(op, addr, bufa, cnt);
        wait_done(cnt * 40 + 100);
        chk(ack_cnt == 1, "ack_pulse", 64'(ack_cnt), 1);
        chk(rise_cnt == 1, "done_rise", 64'(rise_cnt), 1);
    endtask

    initial begin #3000000; $display("FAIL watchdog expired"); $fatal(1, "timeout"); end

    initial begin
        int base;
        bit ok;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_buf_addr = '0; cmd_count = '0;
        for (int i = 0; i < BUF_N; i++) begin rb_mem[i] = $urandom; wb_mem[i] = '0; end
        rb_mem[10'h3FE] = 32'd1; rb_mem[10'h3FF] = 32'd2; rb_mem[0] = 32'd3;
        repeat (3) @(negedge clk);
        chk(dma_done == 1'b1, "rst_done", 64'(dma_done), 1);
        chk({cmd_ack, mem_req, mem_we, rb_re, wb_we} == 5'b0, "rst_strobes",
            64'({cmd_ack, mem_req, mem_we, rb_re, wb_we}), 0);
        chk(mem_addr == 0 && mem_wdata == 0 && wb_addr == 0 && rb_addr == 0, "rst_buses",
            {mem_addr, mem_wdata}, 0);
        @(posedge clk); #1; rstn = 1'b1;
        repeat (2) @(posedge clk); #1;

        // READ 4 words, 2-cycle latency
        lat = 2; gnt_pct = 100;
        run_cmd(1'b0, 32'h100, 0, 4);
        chk(wb_mem[0] == 32'hA5A5A4A5, "wb0_value", 64'(wb_mem[0]), 64'h0A5A5A4A5);
        chk(wb_mem[3] == 32'hA5A5A4A6, "wb3_value", 64'(wb_mem[3]), 64'h0A5A5A4A6);

        // WRITE with buffer wrap
        run_cmd(1'b1, 32'h2000, 10'h3FE, 3);

        // zero-length commands
        for (int op = 0; op < 2; op++) begin
            run_cmd(op[0], 32'h777, 5, 0);
            chk(low_cnt == 2, "zero_done_low", 64'(low_cnt), 2);
            chk(act_cnt == 0, "zero_no_activity", 64'(act_cnt), 0);
        end

        // outstanding limit with long latency
        lat = 8; max_out = 0;
        run_cmd(1'b0, 32'h4000, 20, 16);
        chk(max_out == MAX_OUT, "max_outstanding", 64'(max_out), 64'(MAX_OUT));
        lat = 2;

        // grant withheld, second command waiting behind the first
        hold_gnt = 5;
        ack_cnt = 0;
        issue_cmd(1'b1, 32'h3000, 100, 2);
        rise_cnt = 0;
        push_expect(1'b0, 32'h400, 16, 2);
        cmd_op = 1'b0; cmd_addr = 32'h400; cmd_buf_addr = 10'h10; cmd_count = 16'd2; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            if (cmd_ack) ok = 1'b1;
        end
        cmd_valid = 1'b0;
        @(negedge clk); #1;
        chk(ok, "queued_ack", 64'(ok), 1);
        chk(rise_cnt == 1, "done_before_ack", 64'(rise_cnt), 1);
        chk(last_ack_cyc > last_rise_cyc, "ack_after_done", 64'(last_ack_cyc), 64'(last_rise_cyc + 1));
        wait_done(200);
        hold_gnt = 0;

        // reset in the middle of a READ, then stray responses
        base = wb_seen;
        issue_cmd(1'b0, 32'h5000, 32'h100, 16);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            if (wb_seen - base >= 8) ok = 1'b1;
        end
        chk(ok, "mid_read_progress", 64'(wb_seen - base), 8);
        rstn = 1'b0;
        @(negedge clk);
        chk(dma_done == 1'b1, "midrst_done", 64'(dma_done), 1);
        chk({cmd_ack, mem_req, rb_re, wb_we} == 4'b0, "midrst_strobes",
            64'({cmd_ack, mem_req, rb_re, wb_we}), 0);
        exp_wb.delete();
        @(posedge clk); #1;
        rstn = 1'b1; stray_en = 1'b1;
        base = wb_seen;
        repeat (3) @(posedge clk); #1;
        stray_en = 1'b0;
        @(negedge clk);
        chk(wb_seen == base, "stray_ignored", 64'(wb_seen - base), 0);
        @(posedge clk); #1;
        run_cmd(1'b0, 32'hFFFF_FFFE, 10'h3FF, 4);

        // randomized commands
        for (int n = 0; n < 24; n++) begin
            lat     = $urandom_range(1, 5);
            gnt_pct = $urandom_range(30, 100);
            run_cmd(1'($urandom_range(1)), $urandom, $urandom_range(BUF_N - 1), $urandom_range(0, 12));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
